hba_arbiter: RTL

Round-robin arbiter and bus multiplexer that shares the HomeBrew Automation (HBA) bus between up to NUM_MASTERS bus masters, such as the serial bridge and on-chip sequencers. It sits between the masters and the HBA slave fabric. It grants exactly one master at a time and routes that master's address, control and write data onto the shared bus. A watchdog terminates transfers that no slave acknowledges.

---
 rtl/hba_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hba_arbiter.sv
// hba_arbiter: round-robin arbiter and address/control/data mux for the shared HBA bus,
// with a watchdog that acknowledges transfers no slave answers.
`timescale 1ns/1ps
`default_nettype none

module hba_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      hba_clk,
  input  logic                      hba_reset,
  input  logic [NUM_MASTERS-1:0]    masterx_request,
  input  logic [12*NUM_MASTERS-1:0] master_abus_in,
  input  logic [NUM_MASTERS-1:0]    master_rnw_in,
  input  logic [NUM_MASTERS-1:0]    master_select_in,
  input  logic [8*NUM_MASTERS-1:0]  master_dbus_in,
  input  logic                      hba_xferack,
  output logic [NUM_MASTERS-1:0]    hba_mgrant,
  output logic [11:0]               hba_abus,
  output logic                      hba_rnw,
  output logic                      hba_select,
  output logic [7:0]                hba_mdbus,
  output logic                      hba_xferack_m,
  output logic                      bus_timeout
);

  localparam int             IW       = $clog2(NUM_MASTERS);
  localparam logic [7:0]     TO_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam bit             WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [IW:0]    NM       = (IW+1)'(NUM_MASTERS);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANTED = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [7:0]             wd_cnt_q, wd_cnt_d;
  logic                   to_ack_q, to_ack_d;

  logic                   win_vld;
  logic [IW-1:0]          win_idx;
  logic [NUM_MASTERS-1:0] win_oh;
  logic [IW:0]            rr_sum;

  // Round-robin search starting just after the last winner, wrapping once.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    rr_sum  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      rr_sum = {1'b0, last_q} + (IW+1)'(k + 1);
      if (rr_sum >= NM) begin
        rr_sum = rr_sum - NM;
      end
      if (!win_vld && masterx_request[rr_sum[IW-1:0]]) begin
        win_vld                  = 1'b1;
        win_idx                  = rr_sum[IW-1:0];
        win_oh[rr_sum[IW-1:0]]   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (win_vld) begin
          grant_d = win_oh;
          last_d  = win_idx;
          state_d = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (!(|(masterx_request & grant_q))) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    hba_abus   = '0;
    hba_rnw    = 1'b0;
    hba_select = 1'b0;
    hba_mdbus  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        hba_abus   = master_abus_in[12*k +: 12];
        hba_rnw    = master_rnw_in[k];
        hba_select = master_select_in[k];
        hba_mdbus  = master_dbus_in[8*k +: 8];
      end
    end
  end

  // Counter runs through TO_LIMIT, so expiry lands TIMEOUT_CYCLES+1 edges after select rises.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    to_ack_d = 1'b0;
    if ((state_q != ST_GRANTED) || !hba_select || hba_xferack) begin
      wd_cnt_d = '0;
    end else if (WD_EN) begin
      if (wd_cnt_q == TO_LIMIT) begin
        to_ack_d = 1'b1;
        wd_cnt_d = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state_q  <= ST_IDLE;
      last_q   <= IW'(NUM_MASTERS - 1);
      grant_q  <= '0;
      wd_cnt_q <= '0;
      to_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      wd_cnt_q <= wd_cnt_d;
      to_ack_q <= to_ack_d;
    end
  end

  assign hba_mgrant    = grant_q;
  assign bus_timeout   = to_ack_q;
  assign hba_xferack_m = hba_xferack | to_ack_q;

endmodule

`default_nettype wire
